// File: rtl/assoc_cache_pkg.sv
// Shared types and helpers for the unified set-associative cache.
// Contents: FSM state encoding, access-size codes, latched request payload,
//           size-to-byte-enable and size-to-byte-count helpers.
package assoc_cache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_REFILL = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Request captured from the winning port in IDLE.
  typedef struct packed {
    logic              is_mem;
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Byte lanes touched by an access; unknown size codes behave as a word.
  function automatic logic [3:0] size_be(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_be = 4'b0001;
      SZ_HALF: size_be = 4'b0011;
      default: size_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_nbytes = 3'd1;
      SZ_HALF: size_nbytes = 3'd2;
      default: size_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/assoc_cache_set_array.sv
// Tag/valid/data storage with parallel tag compare across all ways of a set.
// Ports: clk, rst (sync, clears valid bits only)
//        i_idx/i_tag/i_off   : set index, lookup tag, byte offset of the access
//        o_hit/o_hit_way     : tag match and matching way
//        o_inv_any/o_inv_way : lowest-index invalid way of the set
//        o_rword             : 4 bytes starting at i_off in the hit way
//        i_we/i_wway/i_woff/i_wdata/i_wbe : byte-enabled write into set i_idx
//        i_tag_we            : write i_tag into way i_wway and mark it valid
module assoc_cache_set_array
  import assoc_cache_pkg::*;
#(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_BYTES = 16,
  localparam int unsigned OFF_W     = $clog2(LINE_BYTES),
  localparam int unsigned IDX_W     = $clog2(SETS),
  localparam int unsigned TAG_W     = ADDR_W - IDX_W - OFF_W,
  localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [OFF_W-1:0] i_off,
  output logic             o_hit,
  output logic [WAY_W-1:0] o_hit_way,
  output logic             o_inv_any,
  output logic [WAY_W-1:0] o_inv_way,
  output logic [31:0]      o_rword,
  input  logic             i_we,
  input  logic [WAY_W-1:0] i_wway,
  input  logic [OFF_W-1:0] i_woff,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_wbe,
  input  logic             i_tag_we
);

  logic [TAG_W-1:0]           r_tag  [WAYS][SETS];
  logic [7:0]                 r_data [WAYS][SETS][LINE_BYTES];
  logic [WAYS-1:0][SETS-1:0]  r_valid;

  // Scan high to low so the lowest-index way wins for both hit and invalid.
  always_comb begin
    o_hit     = 1'b0;
    o_hit_way = '0;
    o_inv_any = 1'b0;
    o_inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!r_valid[WAY_W'(w)][i_idx]) begin
        o_inv_any = 1'b1;
        o_inv_way = WAY_W'(w);
      end
      if (r_valid[WAY_W'(w)][i_idx] && (r_tag[WAY_W'(w)][i_idx] == i_tag)) begin
        o_hit     = 1'b1;
        o_hit_way = WAY_W'(w);
      end
    end
  end

  // Bytes past the line end wrap; the top masks them by access size.
  always_comb begin
    o_rword = '0;
    for (int b = 0; b < 4; b++) begin
      o_rword[8*b +: 8] = r_data[o_hit_way][i_idx][OFF_W'(i_off + OFF_W'(b))];
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wbe[2'(b)]) begin
          r_data[i_wway][i_idx][OFF_W'(i_woff + OFF_W'(b))] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_tag_we) begin
      r_tag[i_wway][i_idx] <= i_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_wway][i_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Unified set-associative cache shared by the IF and MEM ports in front of a
// byte-wide main memory. Write-through, no-write-allocate, one request at a time.
// Ports: clk, rst (sync active-high)
//        if_req/if_addr -> if_done/if_data                     : word fetch
//        mem_req/mem_we/mem_size/mem_addr/mem_wdata -> mem_done/mem_rdata
//        ram_addr/ram_wr/ram_dout -> memory, ram_din <- memory (1-cycle read latency)
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din
);

  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned CNT_W = OFF_W + 1;

  state_e                   r_state;
  req_t                     r_req;
  logic [CNT_W-1:0]         r_cnt;
  logic [WAY_W-1:0]         r_victim;
  logic [SETS-1:0][WAY_W-1:0] r_rr;
  logic [31:0]              r_acc;
  logic                     r_if_done, r_mem_done, r_ram_wr;
  logic [31:0]              r_if_data, r_mem_rdata, r_ram_addr;
  logic [7:0]               r_ram_dout;

  logic [OFF_W-1:0] w_off, w_k, w_arr_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [3:0]       w_be, w_arr_be;
  logic [31:0]      w_mask, w_rword, w_hit_data, w_acc_next, w_arr_wdata;
  logic             w_hit, w_inv_any, w_cap, w_wr_last, w_arr_we, w_tag_we;
  logic [WAY_W-1:0] w_hit_way, w_inv_way, w_arr_way, w_rr_next;
  logic [CNT_W-1:0] w_rel, w_cnt_p1;
  logic [7:0]       w_wr_byte;

  assign w_off      = r_req.addr[OFF_W-1:0];
  assign w_idx      = r_req.addr[OFF_W +: IDX_W];
  assign w_tag      = r_req.addr[ADDR_W-1 -: TAG_W];
  assign w_be       = size_be(r_req.size);
  assign w_mask     = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_hit_data = w_rword & w_mask;

  // During refill, r_cnt-1 is the line byte arriving on ram_din this cycle.
  assign w_k   = OFF_W'(r_cnt - CNT_W'(1));
  assign w_rel = {1'b0, w_k} - {1'b0, w_off};
  assign w_cap = (r_state == ST_REFILL) && (r_cnt != '0) && (w_k >= w_off) &&
                 (w_rel < CNT_W'(4)) && w_be[w_rel[1:0]];

  // Requested bytes are gathered as they stream in, so the final byte is
  // available in the same cycle it is written to the array.
  always_comb begin
    w_acc_next = r_acc;
    if (w_cap) begin
      w_acc_next[{w_rel[1:0], 3'b000} +: 8] = ram_din;
    end
  end

  assign w_cnt_p1  = r_cnt + CNT_W'(1);
  assign w_wr_byte = r_req.wdata[{w_cnt_p1[1:0], 3'b000} +: 8];
  assign w_wr_last = (r_cnt == CNT_W'(size_nbytes(r_req.size) - 3'd1));
  assign w_rr_next = (r_rr[w_idx] == WAY_W'(WAYS - 1)) ? '0 : WAY_W'(r_rr[w_idx] + 1'b1);

  // Array write port: store-hit update in LOOKUP, streamed line fill in REFILL.
  always_comb begin
    w_arr_we    = 1'b0;
    w_arr_way   = r_victim;
    w_arr_off   = w_k;
    w_arr_wdata = {24'h0, ram_din};
    w_arr_be    = 4'b0001;
    if ((r_state == ST_LOOKUP) && r_req.we && w_hit) begin
      w_arr_we    = 1'b1;
      w_arr_way   = w_hit_way;
      w_arr_off   = w_off;
      w_arr_wdata = r_req.wdata;
      w_arr_be    = w_be;
    end else if ((r_state == ST_REFILL) && (r_cnt != '0)) begin
      w_arr_we = 1'b1;
    end
  end

  assign w_tag_we = (r_state == ST_REFILL) && (r_cnt == CNT_W'(LINE_BYTES));

  assoc_cache_set_array #(
    .WAYS       (WAYS),
    .SETS       (SETS),
    .LINE_BYTES (LINE_BYTES)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_idx     (w_idx),
    .i_tag     (w_tag),
    .i_off     (w_off),
    .o_hit     (w_hit),
    .o_hit_way (w_hit_way),
    .o_inv_any (w_inv_any),
    .o_inv_way (w_inv_way),
    .o_rword   (w_rword),
    .i_we      (w_arr_we),
    .i_wway    (w_arr_way),
    .i_woff    (w_arr_off),
    .i_wdata   (w_arr_wdata),
    .i_wbe     (w_arr_be),
    .i_tag_we  (w_tag_we)
  );

  // Arbiter + request FSM; done pulses last exactly the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_cnt       <= '0;
      r_victim    <= '0;
      r_rr        <= '0;
      r_acc       <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_ram_addr  <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= '0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_req) begin
            r_req   <= '{is_mem: 1'b1, we: mem_we, size: mem_size, addr: mem_addr, wdata: mem_wdata};
            r_state <= ST_LOOKUP;
          end else if (if_req) begin
            r_req   <= '{is_mem: 1'b0, we: 1'b0, size: SZ_WORD, addr: if_addr, wdata: 32'h0};
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_cnt <= '0;
          r_acc <= '0;
          if (r_req.we) begin
            r_ram_wr   <= 1'b1;
            r_ram_addr <= r_req.addr;
            r_ram_dout <= r_req.wdata[7:0];
            r_state    <= ST_WRITE;
          end else if (w_hit) begin
            if (r_req.is_mem) begin
              r_mem_rdata <= w_hit_data;
              r_mem_done  <= 1'b1;
            end else begin
              r_if_data <= w_hit_data;
              r_if_done <= 1'b1;
            end
            r_state <= ST_DONE;
          end else begin
            r_victim   <= w_inv_any ? w_inv_way : r_rr[w_idx];
            r_ram_addr <= {r_req.addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            r_state    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          r_cnt <= w_cnt_p1;
          r_acc <= w_acc_next;
          if (r_cnt < CNT_W'(LINE_BYTES - 1)) begin
            r_ram_addr <= r_ram_addr + 32'd1;
          end
          if (r_cnt == CNT_W'(LINE_BYTES)) begin
            r_rr[w_idx] <= w_rr_next;
            if (r_req.is_mem) begin
              r_mem_rdata <= w_acc_next;
              r_mem_done  <= 1'b1;
            end else begin
              r_if_data <= w_acc_next;
              r_if_done <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end
        ST_WRITE: begin
          if (w_wr_last) begin
            r_ram_wr   <= 1'b0;
            r_mem_done <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_cnt      <= w_cnt_p1;
            r_ram_addr <= r_ram_addr + 32'd1;
            r_ram_dout <= w_wr_byte;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_done   = r_if_done;
  assign if_data   = r_if_data;
  assign mem_done  = r_mem_done;
  assign mem_rdata = r_mem_rdata;
  assign ram_addr  = r_ram_addr;
  assign ram_wr    = r_ram_wr;
  assign ram_dout  = r_ram_dout;

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (WAYS=4, SETS=64, LINE_BYTES=16) against a
// byte-wide memory model with one-cycle read latency.
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, mem_req, mem_we, mem_done, ram_wr;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_addr;
  logic [1:0]  mem_size;
  logic [7:0]  ram_dout, ram_din;

  always #5 clk = ~clk;

  assoc_cache #(.WAYS(4), .SETS(64), .LINE_BYTES(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 13 + (a >> 8)) ^ 8'h5A);
  endfunction

  // Main memory model.
  logic [7:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr[15:0]] = ram_dout;
    ram_din <= mem[ram_addr[15:0]];
  end

  // Bus monitor: address changes, writes and done pulses.
  int          chg_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] chg_a [0:255];
  logic [31:0] wr_a  [0:255];
  logic [7:0]  wr_d  [0:255];
  always @(posedge clk) begin
    if (ram_addr != prev_addr) begin
      chg_a[chg_cnt % 256] <= ram_addr;
      chg_cnt <= chg_cnt + 1;
    end
    prev_addr <= ram_addr;
    if (ram_wr) begin
      wr_a[wr_cnt % 256] <= ram_addr;
      wr_d[wr_cnt % 256] <= ram_dout;
      wr_cnt <= wr_cnt + 1;
    end
    if (if_done || mem_done) done_cnt <= done_cnt + 1;
  end

  logic [7:0] exp_mem [0:65535];
  int total = 0, bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one request (called #1 after an edge with the FSM idle); returns
  // the number of edges until done is seen and the returned data.
  task automatic run_txn(input logic is_mem, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd);
    logic seen;
    lat = 0; rd = 32'h0; seen = 1'b0;
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      seen = is_mem ? mem_done : if_done;
    end
    rd = is_mem ? mem_rdata : if_data;
    mem_req = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a, input int nb);
    logic [31:0] v;
    v = 32'h0;
    for (int j = 0; j < nb; j++) v[8*j +: 8] = exp_mem[16'(a + 32'(j))];
    return v;
  endfunction

  task automatic read_chk(input string nm, input logic [31:0] a, input int exp_lat);
    int lat; logic [31:0] rd;
    run_txn(1'b0, 1'b0, 2'd2, a, 32'h0, lat, rd);
    check({nm, " lat"}, 32'(lat), 32'(exp_lat));
    check({nm, " data"}, rd, exp_read(a, 4));
  endtask

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } vec_t;

  vec_t vt [10];

  initial begin
    int lat, nb, n0_chg, n0_wr, n0_done, c0, if_t, mem_t, cyc;
    logic [31:0] rd, id, md;
    logic found;

    for (int i = 0; i < 65536; i++) exp_mem[i] = init_byte(i);
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;

    vt[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0,          19}; // cold fetch
    vt[1] = '{1'b0, 1'b0, 2'd2, 32'h0000_1004, 32'h0,           2}; // fetch hit
    vt[2] = '{1'b1, 1'b1, 2'd2, 32'h0000_1008, 32'hDEAD_BEEF,   6}; // store word hit
    vt[3] = '{1'b0, 1'b0, 2'd2, 32'h0000_1008, 32'h0,           2}; // fetch sees store
    vt[4] = '{1'b1, 1'b0, 2'd1, 32'h0000_100A, 32'h0,           2}; // load half hit
    vt[5] = '{1'b1, 1'b1, 2'd0, 32'h0000_100D, 32'h0000_005A,   3}; // store byte hit
    vt[6] = '{1'b1, 1'b0, 2'd2, 32'h0000_100C, 32'h0,           2}; // load word hit
    vt[7] = '{1'b1, 1'b1, 2'd1, 32'h0000_2002, 32'h0000_1234,   4}; // store half miss
    vt[8] = '{1'b1, 1'b0, 2'd1, 32'h0000_2002, 32'h0,          19}; // no allocate -> miss
    vt[9] = '{1'b1, 1'b0, 2'd0, 32'h0000_100F, 32'h0,           2}; // load last byte of line

    repeat (3) @(posedge clk);
    #1;
    check("rst if_done", 32'(if_done), 32'h0);
    check("rst mem_done", 32'(mem_done), 32'h0);
    check("rst ram_wr", 32'(ram_wr), 32'h0);
    check("rst ram_addr", ram_addr, 32'h0);
    check("rst if_data", if_data, 32'h0);
    check("rst mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      nb = (vt[i].size == 2'd0) ? 1 : (vt[i].size == 2'd1) ? 2 : 4;
      n0_chg = chg_cnt; n0_wr = wr_cnt;
      run_txn(vt[i].is_mem, vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata, lat, rd);
      check($sformatf("v%0d lat", i), 32'(lat), 32'(vt[i].lat));
      if (vt[i].we) begin
        check($sformatf("v%0d wr count", i), 32'(wr_cnt - n0_wr), 32'(nb));
        for (int j = 0; j < nb; j++) begin
          check($sformatf("v%0d wr%0d addr", i, j), wr_a[(n0_wr + j) % 256], vt[i].addr + 32'(j));
          check($sformatf("v%0d wr%0d byte", i, j), 32'(wr_d[(n0_wr + j) % 256]), 32'(vt[i].wdata[8*j +: 8]));
          exp_mem[16'(vt[i].addr + 32'(j))] = vt[i].wdata[8*j +: 8];
        end
      end else begin
        check($sformatf("v%0d data", i), rd, exp_read(vt[i].addr, nb));
        check($sformatf("v%0d ram reads", i), 32'(chg_cnt - n0_chg), (vt[i].lat == 2) ? 32'd0 : 32'd16);
        check($sformatf("v%0d no writes", i), 32'(wr_cnt - n0_wr), 32'd0);
      end
      if (i == 0) begin
        check("v0 first ram addr", chg_a[n0_chg % 256], 32'h0000_1000);
        check("v0 last ram addr", chg_a[(n0_chg + 15) % 256], 32'h0000_100F);
      end
      if (i == 3) check("v3 stored word", rd, 32'hDEAD_BEEF);
    end

    // Simultaneous requests: MEM wins, IF waits and is served afterwards.
    if_req = 1'b1; if_addr = 32'h0000_1004;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h0000_1003;
    if_t = 0; mem_t = 0; cyc = 0; id = 32'h0; md = 32'h0;
    while ((if_t == 0 || mem_t == 0) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_done && mem_t == 0) begin mem_t = cyc; md = mem_rdata; mem_req = 1'b0; end
      if (if_done && if_t == 0) begin if_t = cyc; id = if_data; if_req = 1'b0; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
    check("arb mem lat", 32'(mem_t), 32'd2);
    check("arb if lat", 32'(if_t), 32'd5);
    check("arb mem data", md, exp_read(32'h0000_1003, 1));
    check("arb if data", id, exp_read(32'h0000_1004, 4));

    // Replacement in set 0: four cold fills, fifth evicts way 0.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    read_chk("rp 2000", 32'h0000_2000, 19);
    read_chk("rp 2400", 32'h0000_2400, 19);
    read_chk("rp 2800", 32'h0000_2800, 19);
    read_chk("rp 2C00", 32'h0000_2C00, 19);
    read_chk("rp 3000", 32'h0000_3000, 19);
    read_chk("rp 2400 hit", 32'h0000_2400, 2);
    read_chk("rp 2000 again", 32'h0000_2000, 19);
    read_chk("rp 2800 hit", 32'h0000_2800, 2);
    read_chk("rp 2400 evicted", 32'h0000_2404, 19);

    // Reset in the middle of a refill.
    if_addr = 32'h0000_4000; if_req = 1'b1; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      if (ram_addr == 32'h0000_4007) found = 1'b1;
    end
    check("mid-refill reached", 32'(found), 32'h1);
    n0_done = done_cnt;
    rst = 1'b1; if_req = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid-refill no done", 32'(done_cnt - n0_done), 32'h0);
    check("mid-refill ram_addr", ram_addr, 32'h0);
    c0 = chg_cnt;
    read_chk("after rst 4000", 32'h0000_4000, 19);
    check("after rst refill reads", 32'(chg_cnt - c0), 32'd16);
    read_chk("after rst 2800", 32'h0000_2800, 19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
